// File: rtl/l2_cache_assoc_if.sv
// rtl/l2_cache_assoc_if.sv - request/response, refill, flush and counter signals of the L2 cache
interface l2_cache_assoc_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic              resp_hit;
  logic [DATA_W-1:0] resp_data;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;
  logic              flush;
  logic              flush_done;
  logic [CNT_W-1:0]  hit_cnt;
  logic [CNT_W-1:0]  miss_cnt;

  modport slave (
    input  req_valid, req_addr, mem_req_ready, mem_resp_valid, mem_resp_data, flush,
    output req_ready, resp_valid, resp_hit, resp_data, mem_req_valid, mem_req_addr,
           flush_done, hit_cnt, miss_cnt
  );

  modport master (
    output req_valid, req_addr, mem_req_ready, mem_resp_valid, mem_resp_data, flush,
    input  req_ready, resp_valid, resp_hit, resp_data, mem_req_valid, mem_req_addr,
           flush_done, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/l2_cache_assoc.sv
// rtl/l2_cache_assoc.sv - read-only N-way set-associative L2 cache with true-LRU replacement
module l2_cache_assoc #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 32,
  parameter int OFFSET_W = 5,
  parameter int NUM_SETS = 8,
  parameter int NUM_WAYS = 2,
  parameter int CNT_W    = 16
) (
  input logic             clk,
  input logic             rst_n,
  l2_cache_assoc_if.slave bus
);
  localparam int INDEX_W = $clog2(NUM_SETS);
  localparam int TAG_W   = ADDR_W - OFFSET_W - INDEX_W;
  localparam int WAY_W   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam logic [WAY_W-1:0] OLDEST = WAY_W'(NUM_WAYS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEM_REQ,
    REFILL_WAIT,
    RESPOND
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [WAY_W-1:0]    age_q   [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
  logic [DATA_W-1:0]   data_q  [NUM_SETS][NUM_WAYS];

  logic              resp_valid_q;
  logic              resp_hit_q;
  logic [DATA_W-1:0] resp_data_q;
  logic              mem_req_valid_q;
  logic [ADDR_W-1:0] mem_req_addr_q;
  logic              flush_done_q;
  logic [CNT_W-1:0]  hit_cnt_q;
  logic [CNT_W-1:0]  miss_cnt_q;

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_idx;
  logic [OFFSET_W-1:0] unused_offset;

  assign req_tag       = addr_q[ADDR_W-1 -: TAG_W];
  assign req_idx       = addr_q[OFFSET_W +: INDEX_W];
  assign unused_offset = addr_q[OFFSET_W-1:0];

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic             victim_found;
  logic [WAY_W-1:0] victim_way;
  logic [WAY_W-1:0] touch_way;
  logic             do_fill;
  logic             do_touch;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!hit && valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Fill empty ways first (lowest index), otherwise evict the least recently used way.
  always_comb begin
    victim_found = 1'b0;
    victim_way   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!victim_found && !valid_q[req_idx][w]) begin
        victim_found = 1'b1;
        victim_way   = WAY_W'(w);
      end
    end
    if (!victim_found) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (age_q[req_idx][w] == OLDEST) begin
          victim_way = WAY_W'(w);
        end
      end
    end
  end

  assign do_fill   = (state_q == REFILL_WAIT) && bus.mem_resp_valid;
  assign do_touch  = ((state_q == LOOKUP) && hit) || do_fill;
  assign touch_way = (state_q == LOOKUP) ? hit_way : victim_way;

  always_ff @(posedge clk) begin
    if (do_fill) begin
      tag_q[req_idx][victim_way]  <= req_tag;
      data_q[req_idx][victim_way] <= bus.mem_resp_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      resp_valid_q    <= 1'b0;
      resp_hit_q      <= 1'b0;
      resp_data_q     <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
      flush_done_q    <= 1'b0;
      hit_cnt_q       <= '0;
      miss_cnt_q      <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
          age_q[s][w] <= WAY_W'(w);
        end
      end
    end else begin
      resp_valid_q <= 1'b0;
      flush_done_q <= 1'b0;

      // Touched way becomes youngest; only younger ways age, so ages stay a permutation.
      if (do_touch) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (WAY_W'(w) == touch_way) begin
            age_q[req_idx][w] <= '0;
          end else if (age_q[req_idx][w] < age_q[req_idx][touch_way]) begin
            age_q[req_idx][w] <= age_q[req_idx][w] + 1'b1;
          end
        end
      end

      case (state_q)
        IDLE: begin
          if (bus.flush) begin
            flush_done_q <= 1'b1;
            for (int s = 0; s < NUM_SETS; s++) begin
              valid_q[s] <= '0;
              for (int w = 0; w < NUM_WAYS; w++) begin
                age_q[s][w] <= WAY_W'(w);
              end
            end
          end else if (bus.req_valid) begin
            addr_q  <= bus.req_addr;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            resp_hit_q  <= 1'b1;
            resp_data_q <= data_q[req_idx][hit_way];
            if (hit_cnt_q != {CNT_W{1'b1}}) begin
              hit_cnt_q <= hit_cnt_q + 1'b1;
            end
            state_q <= RESPOND;
          end else begin
            if (miss_cnt_q != {CNT_W{1'b1}}) begin
              miss_cnt_q <= miss_cnt_q + 1'b1;
            end
            mem_req_valid_q <= 1'b1;
            mem_req_addr_q  <= {req_tag, req_idx, {OFFSET_W{1'b0}}};
            state_q         <= MEM_REQ;
          end
        end
        MEM_REQ: begin
          if (bus.mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= REFILL_WAIT;
          end
        end
        REFILL_WAIT: begin
          if (bus.mem_resp_valid) begin
            valid_q[req_idx][victim_way] <= 1'b1;
            resp_hit_q  <= 1'b0;
            resp_data_q <= bus.mem_resp_data;
            state_q     <= RESPOND;
          end
        end
        RESPOND: begin
          resp_valid_q <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready     = (state_q == IDLE) && !bus.flush;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_hit      = resp_hit_q;
  assign bus.resp_data     = resp_data_q;
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_req_addr  = mem_req_addr_q;
  assign bus.flush_done    = flush_done_q;
  assign bus.hit_cnt       = hit_cnt_q;
  assign bus.miss_cnt      = miss_cnt_q;
endmodule

// File: tb/tb_l2_cache_assoc.sv
// tb/tb_l2_cache_assoc.sv - scoreboard bench for l2_cache_assoc; a 2-bit-counter twin shares stimulus
module tb_l2_cache_assoc;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  l2_cache_assoc_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();
  l2_cache_assoc_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(2))     sbus ();

  l2_cache_assoc #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OFFSET_W(5), .NUM_SETS(8),
                   .NUM_WAYS(2), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  l2_cache_assoc #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OFFSET_W(5), .NUM_SETS(8),
                   .NUM_WAYS(2), .CNT_W(2)) dut_sat (.clk(clk), .rst_n(rst_n), .bus(sbus));

  assign sbus.req_valid      = bus.req_valid;
  assign sbus.req_addr       = bus.req_addr;
  assign sbus.mem_req_ready  = bus.mem_req_ready;
  assign sbus.mem_resp_valid = bus.mem_resp_valid;
  assign sbus.mem_resp_data  = bus.mem_resp_data;
  assign sbus.flush          = bus.flush;

  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(negedge clk) begin
    if (rst_n && bus.resp_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_resp: resp_valid=1 hit=%0b data=%h, required no response",
                 bus.resp_hit, bus.resp_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ({bus.resp_hit, bus.resp_data} !== {mon_e.hit, mon_e.data}) begin
          n_fail++;
          $display("FAIL resp: hit=%0b data=%h, required hit=%0b data=%h",
                   bus.resp_hit, bus.resp_data, mon_e.hit, mon_e.data);
        end
      end
    end
  end

  task automatic apply_reset();
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0; bus.flush = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives one read and acts as the refill memory; reports timing, no checking here.
  task automatic read_txn(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] mdata,
                          input int stall, output int lat, output int refill_gap,
                          output bit went_mem, output logic [ADDR_W-1:0] maddr,
                          output bit stable, output bit done);
    int phase, st, refill_edge, wait_cyc;
    lat = 0; refill_gap = -1; went_mem = 0; maddr = '0; stable = 1; done = 0;
    phase = 0; st = 0; refill_edge = 0; wait_cyc = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr = addr;
    while (!bus.req_ready && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (!bus.req_ready) begin
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.resp_valid) begin
        done = 1;
        if (refill_edge > 0) refill_gap = lat - refill_edge;
        break;
      end
      case (phase)
        0: begin
          if (went_mem && !bus.mem_req_valid) stable = 0;
          else if (bus.mem_req_valid) begin
            if (!went_mem) maddr = bus.mem_req_addr;
            went_mem = 1;
            if (bus.mem_req_addr !== maddr || bus.req_ready !== 1'b0) stable = 0;
            if (st >= stall) begin
              bus.mem_req_ready = 1'b1;
              phase = 1;
            end else st++;
          end
        end
        1: begin
          bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_resp_data = mdata;
          phase = 2;
        end
        2: begin
          bus.mem_resp_valid = 1'b0; refill_edge = lat; phase = 3;
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({bus.resp_valid, bus.resp_hit, bus.resp_data, bus.mem_req_valid, bus.mem_req_addr,
         bus.flush_done, bus.hit_cnt, bus.miss_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rv=%0b rh=%0b rd=%h mv=%0b ma=%h fd=%0b hc=%0d mc=%0d, required all 0",
               bus.resp_valid, bus.resp_hit, bus.resp_data, bus.mem_req_valid, bus.mem_req_addr,
               bus.flush_done, bus.hit_cnt, bus.miss_cnt);
    end
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_req_ready: %0b required 1", bus.req_ready);
    end
  endtask

  task automatic test_basic();
    int lat, gap; bit wm, st, dn; logic [ADDR_W-1:0] ma;
    apply_reset();
    exp_q.push_back('{hit: 1'b0, data: 32'hFEEDFACE});
    read_txn(11'h120, 32'hFEEDFACE, 0, lat, gap, wm, ma, st, dn);
    n_checks++;
    if ({dn, wm, ma} !== {1'b1, 1'b1, 11'h120}) begin
      n_fail++; $display("FAIL basic_miss: done=%0b mem=%0b addr=%h, required 1 1 120", dn, wm, ma);
    end
    exp_q.push_back('{hit: 1'b1, data: 32'hFEEDFACE});
    read_txn(11'h12C, 32'h0, 0, lat, gap, wm, ma, st, dn);
    n_checks++;
    if ({dn, wm} !== 2'b10 || lat != 2) begin
      n_fail++; $display("FAIL basic_hit: done=%0b mem=%0b lat=%0d, required 1 0 2", dn, wm, lat);
    end
    n_checks++;
    if (bus.hit_cnt !== 16'd1 || bus.miss_cnt !== 16'd1) begin
      n_fail++; $display("FAIL basic_cnt: hit=%0d miss=%0d, required 1 1", bus.hit_cnt, bus.miss_cnt);
    end
  endtask

  task automatic test_lru();
    logic [ADDR_W-1:0] a_tab [6] = '{11'h020, 11'h120, 11'h020, 11'h220, 11'h020, 11'h120};
    logic              h_tab [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [DATA_W-1:0] d_tab [6] = '{32'hA0000020, 32'hB0000120, 32'hA0000020,
                                     32'hC0000220, 32'hA0000020, 32'hD0000120};
    int lat, gap; bit wm, st, dn; logic [ADDR_W-1:0] ma;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back('{hit: h_tab[i], data: d_tab[i]});
      read_txn(a_tab[i], d_tab[i], 0, lat, gap, wm, ma, st, dn);
      n_checks++;
      if (!dn || wm !== !h_tab[i] || (wm && ma !== a_tab[i])) begin
        n_fail++;
        $display("FAIL lru_step%0d: done=%0b mem=%0b addr=%h, required done=1 mem=%0b addr=%h",
                 i, dn, wm, ma, !h_tab[i], a_tab[i]);
      end
    end
  endtask

  task automatic test_mem_stall();
    int lat, gap; bit wm, st, dn; logic [ADDR_W-1:0] ma;
    apply_reset();
    exp_q.push_back('{hit: 1'b0, data: 32'h13579BDF});
    read_txn(11'h3E7, 32'h13579BDF, 5, lat, gap, wm, ma, st, dn);
    n_checks++;
    if ({dn, wm, st, ma} !== {3'b111, 11'h3E0}) begin
      n_fail++;
      $display("FAIL stall_req: done=%0b mem=%0b stable=%0b addr=%h, required 1 1 1 3e0", dn, wm, st, ma);
    end
    n_checks++;
    if (gap != 1) begin
      n_fail++; $display("FAIL stall_resp_gap: %0d cycles after refill, required 1", gap);
    end
  endtask

  task automatic test_flush();
    int lat, gap; bit wm, st, dn; logic [ADDR_W-1:0] ma;
    apply_reset();
    exp_q.push_back('{hit: 1'b0, data: 32'h11111111});
    read_txn(11'h040, 32'h11111111, 0, lat, gap, wm, ma, st, dn);
    exp_q.push_back('{hit: 1'b0, data: 32'h22222222});
    read_txn(11'h160, 32'h22222222, 0, lat, gap, wm, ma, st, dn);
    @(negedge clk);
    bus.flush = 1'b1; bus.req_valid = 1'b1; bus.req_addr = 11'h040;
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b0) begin
      n_fail++; $display("FAIL flush_req_ready: %0b required 0", bus.req_ready);
    end
    @(posedge clk);
    #1 bus.flush = 1'b0; bus.req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.flush_done, bus.req_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL flush_done_pulse: done=%0b ready=%0b, required 1 1", bus.flush_done, bus.req_ready);
    end
    @(negedge clk);
    n_checks++;
    if (bus.flush_done !== 1'b0) begin
      n_fail++; $display("FAIL flush_done_width: %0b required 0", bus.flush_done);
    end
    exp_q.push_back('{hit: 1'b0, data: 32'h33333333});
    read_txn(11'h040, 32'h33333333, 0, lat, gap, wm, ma, st, dn);
    n_checks++;
    if ({dn, wm} !== 2'b11) begin
      n_fail++; $display("FAIL flush_line0: done=%0b mem=%0b, required 1 1", dn, wm);
    end
    exp_q.push_back('{hit: 1'b0, data: 32'h44444444});
    read_txn(11'h160, 32'h44444444, 0, lat, gap, wm, ma, st, dn);
    n_checks++;
    if ({dn, wm} !== 2'b11) begin
      n_fail++; $display("FAIL flush_line1: done=%0b mem=%0b, required 1 1", dn, wm);
    end
  endtask

  task automatic test_reset_abort();
    int lat, gap, cyc, seen; bit wm, st, dn; logic [ADDR_W-1:0] ma;
    apply_reset();
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr = 11'h0A0;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.mem_req_valid && cyc < 20);
    n_checks++;
    if (bus.mem_req_valid !== 1'b1) begin
      n_fail++; $display("FAIL abort_mem_req: mem_req_valid=%0b required 1", bus.mem_req_valid);
    end
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.resp_valid, bus.mem_req_valid, bus.mem_req_addr, bus.miss_cnt, bus.resp_data} !== '0) begin
      n_fail++;
      $display("FAIL abort_outputs: rv=%0b mv=%0b ma=%h mc=%0d rd=%h, required all 0",
               bus.resp_valid, bus.mem_req_valid, bus.mem_req_addr, bus.miss_cnt, bus.resp_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'hDEADBEEF;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.resp_valid || bus.mem_req_valid) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("FAIL abort_quiet: %0d active cycles, required 0", seen);
    end
    exp_q.push_back('{hit: 1'b0, data: 32'h5555AAAA});
    read_txn(11'h0A0, 32'h5555AAAA, 0, lat, gap, wm, ma, st, dn);
    n_checks++;
    if ({dn, wm} !== 2'b11) begin
      n_fail++; $display("FAIL abort_late_data: done=%0b mem=%0b, required 1 1", dn, wm);
    end
  endtask

  task automatic test_saturation();
    int lat, gap, exp_s; bit wm, st, dn; logic [ADDR_W-1:0] ma;
    logic [ADDR_W-1:0] a;
    apply_reset();
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 4; i++) begin
        a = ADDR_W'(i * 32);
        exp_q.push_back('{hit: (pass == 1), data: 32'h60000000 + 32'(i)});
        read_txn(a, 32'h60000000 + 32'(i), 0, lat, gap, wm, ma, st, dn);
        exp_s = (i + 1 > 3) ? 3 : i + 1;
        n_checks++;
        if (pass == 0 && (sbus.miss_cnt !== 2'(exp_s) || bus.miss_cnt !== 16'(i + 1))) begin
          n_fail++;
          $display("FAIL sat_miss%0d: sat=%0d wide=%0d, required %0d %0d",
                   i, sbus.miss_cnt, bus.miss_cnt, exp_s, i + 1);
        end else if (pass == 1 && (sbus.hit_cnt !== 2'(exp_s) || sbus.miss_cnt !== 2'd3)) begin
          n_fail++;
          $display("FAIL sat_hit%0d: sat_hit=%0d sat_miss=%0d, required %0d 3",
                   i, sbus.hit_cnt, sbus.miss_cnt, exp_s);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lru();
    test_mem_stall();
    test_flush();
    test_reset_abort();
    test_saturation();
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL missing_resp: %0d responses outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
